// File: rtl/seg7_digit_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_driver_if
// Description : Valid/ready digit transfer bundle between an upstream BCD
//               counter stage (master) and the 7-segment driver (slave).
//   bcd_in    : 4-bit digit code, master -> slave
//   bcd_valid : bcd_in carries a digit, master -> slave
//   bcd_ready : slave accepts a digit this cycle, slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_digit_driver_if;
  logic [3:0] bcd_in;
  logic       bcd_valid;
  logic       bcd_ready;

  modport master (output bcd_in, output bcd_valid, input  bcd_ready);
  modport slave  (input  bcd_in, input  bcd_valid, output bcd_ready);
endinterface
`default_nettype wire

// File: rtl/seg7_digit_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_driver
// Description : Accepts BCD digits over a valid/ready handshake, holds each
//               for HOLD_CYCLES cycles, and drives one active-low 7-segment
//               display with optional blinking and zero blanking.
//   CLOCK_50   : clock, all state on rising edge
//   RESET      : asynchronous active-high reset
//   bus        : slave side of the digit handshake (bcd_in/valid/ready)
//   blink_en   : level, 1 = flash the displayed digit
//   blank_zero : level, 1 = show digit 0 as all segments off
//   HEX0       : registered active-low segments, HEX0[0]=a ... HEX0[6]=g
//   err        : registered, 1 while the held code is 10..15
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_digit_driver #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_BITS  = 24
) (
  input  wire                        CLOCK_50,
  input  wire                        RESET,
  seg7_digit_driver_if.slave         bus,
  input  wire                        blink_en,
  input  wire                        blank_zero,
  output logic [0:6]                 HEX0,
  output logic                       err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int                    HOLD_W    = 26;
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);
  localparam logic [BLINK_BITS-1:0] BLINK_ONE = BLINK_BITS'(1);
  localparam logic [0:6]            SEG_OFF   = 7'b1111111;

  state_t                state_q, state_d;
  logic [3:0]            digit_q, digit_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [0:6]            hex_q, hex_d;
  logic                  err_q, err_d;
  logic                  xfer;

  function automatic logic [0:6] decode(input logic [3:0] d);
    logic [0:6] seg;
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111110;  // dash for non-BCD codes
    endcase
    return seg;
  endfunction

  // Ready is a pure function of state; while RESET is high state is EMPTY so
  // ready reads 1, but the asynchronous reset keeps any edge from capturing.
  assign bus.bcd_ready = (state_q != ST_HOLD);
  assign xfer          = bus.bcd_valid && bus.bcd_ready;

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    hold_d  = hold_q;
    blink_d = blink_q + BLINK_ONE;  // free-running, wraps naturally

    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_HOLD;
      ST_HOLD: begin
        hold_d = hold_q + HOLD_ONE;
        if (hold_q == HOLD_LAST) state_d = ST_SHOW;
      end
      ST_SHOW:  if (xfer) state_d = ST_HOLD;
      default:  state_d = ST_EMPTY;
    endcase

    // Restarting the blink phase on each transfer guarantees the new digit
    // is visible for the first half-period even when blinking.
    if (xfer) begin
      digit_d = bus.bcd_in;
      hold_d  = '0;
      blink_d = '0;
    end

    err_d = (digit_d > 4'd9);

    // Display is computed from next-state values so a captured digit shows
    // right after its transfer edge.
    if (state_d == ST_EMPTY)
      hex_d = SEG_OFF;
    else if (blink_en && blink_d[BLINK_BITS-1])
      hex_d = SEG_OFF;
    else if (blank_zero && (digit_d == 4'd0))
      hex_d = SEG_OFF;
    else
      hex_d = decode(digit_d);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      digit_q <= '0;
      hold_q  <= '0;
      blink_q <= '0;
      hex_q   <= SEG_OFF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      hex_q   <= hex_d;
      err_q   <= err_d;
    end
  end

  assign HEX0 = hex_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_digit_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_digit_driver
// Description : Self-checking bench for seg7_digit_driver (HOLD_CYCLES=4,
//               BLINK_BITS=3). Expected display/err values are queued when a
//               digit is offered and compared one cycle after the transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_digit_driver;

  localparam int         HOLD   = 4;
  localparam logic [0:6] OFF    = 7'b1111111;
  localparam logic [0:6] DASH   = 7'b1111110;
  localparam logic [0:6] SEG5   = 7'b0100100;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       blink_en;
  logic       blank_zero;
  logic [0:6] HEX0;
  logic       err;

  seg7_digit_driver_if bus();

  seg7_digit_driver #(.HOLD_CYCLES(HOLD), .BLINK_BITS(3)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .bus        (bus),
    .blink_en   (blink_en),
    .blank_zero (blank_zero),
    .HEX0       (HEX0),
    .err        (err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0] code;
    logic       bz;
    logic [0:6] hex;
    logic       e;
  } vec_t;

  typedef struct {
    logic [0:6] hex;
    logic       e;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a transfer is decided before the edge (sampled at negedge),
  // its result is checked #1 after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (bus.bcd_valid && bus.bcd_ready && !RESET) begin
        @(posedge CLOCK_50);
        #1;
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_hex"}, 32'(HEX0), 32'(e.hex));
          chk({e.name, "_err"}, 32'(err), 32'(e.e));
        end
      end
    end
  end

  task automatic send(input logic [3:0] code, input logic [0:6] hex,
                      input logic e, input string name);
    exp_t x;
    int   n;
    x.hex = hex; x.e = e; x.name = name;
    exp_q.push_back(x);
    bus.bcd_in    = code;
    bus.bcd_valid = 1'b1;
    n = 0;
    while (!bus.bcd_ready) begin
      @(posedge CLOCK_50); #1;
      n++;
      if (n > 40) begin
        chk({name, "_ready_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
    @(posedge CLOCK_50); #1;
  endtask

  // Called #1 after a transfer edge: ready must stay low exactly HOLD cycles.
  task automatic hold_check(input string name);
    int n;
    n = 0;
    while (!bus.bcd_ready && n < 20) begin
      n++;
      @(posedge CLOCK_50); #1;
    end
    chk({name, "_hold_len"}, 32'(n), 32'(HOLD));
  endtask

  vec_t vecs[18];

  initial begin : main
    vecs[0]  = '{4'd0,  1'b0, 7'b0000001, 1'b0};
    vecs[1]  = '{4'd1,  1'b0, 7'b1001111, 1'b0};
    vecs[2]  = '{4'd2,  1'b0, 7'b0010010, 1'b0};
    vecs[3]  = '{4'd3,  1'b0, 7'b0000110, 1'b0};
    vecs[4]  = '{4'd4,  1'b0, 7'b1001100, 1'b0};
    vecs[5]  = '{4'd5,  1'b0, 7'b0100100, 1'b0};
    vecs[6]  = '{4'd6,  1'b0, 7'b0100000, 1'b0};
    vecs[7]  = '{4'd7,  1'b0, 7'b0001111, 1'b0};
    vecs[8]  = '{4'd8,  1'b0, 7'b0000000, 1'b0};
    vecs[9]  = '{4'd9,  1'b0, 7'b0000100, 1'b0};
    vecs[10] = '{4'd0,  1'b0, 7'b0000001, 1'b0};
    vecs[11] = '{4'd12, 1'b0, DASH,       1'b1};
    vecs[12] = '{4'd3,  1'b0, 7'b0000110, 1'b0};
    vecs[13] = '{4'd15, 1'b0, DASH,       1'b1};
    vecs[14] = '{4'd9,  1'b0, 7'b0000100, 1'b0};
    vecs[15] = '{4'd0,  1'b1, OFF,        1'b0};
    vecs[16] = '{4'd10, 1'b1, DASH,       1'b1};
    vecs[17] = '{4'd1,  1'b1, 7'b1001111, 1'b0};

    RESET = 1'b1; blink_en = 1'b0; blank_zero = 1'b0;
    bus.bcd_in = 4'd0; bus.bcd_valid = 1'b0;

    // Reset state, and valid offered while in reset must not transfer
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("reset_hex", 32'(HEX0), 32'(OFF));
    chk("reset_ready", 32'(bus.bcd_ready), 32'd1);
    chk("reset_err", 32'(err), 32'd0);
    bus.bcd_in = 4'd7; bus.bcd_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("reset_no_capture", 32'(HEX0), 32'(OFF));
    bus.bcd_valid = 1'b0;
    RESET = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("empty_hex", 32'(HEX0), 32'(OFF));

    // First digit after reset release
    send(4'd7, 7'b0001111, 1'b0, "first7");
    bus.bcd_valid = 1'b0;
    hold_check("first7");
    chk("first7_show_hex", 32'(HEX0), 32'(7'b0001111));

    // Table: back-to-back with valid held, wrap, error codes, zero blanking
    for (int i = 0; i < 18; i++) begin
      blank_zero = vecs[i].bz;
      send(vecs[i].code, vecs[i].hex, vecs[i].e, $sformatf("vec%0d", i));
      hold_check($sformatf("vec%0d", i));
    end
    bus.bcd_valid = 1'b0;
    blank_zero    = 1'b0;

    // Blink: digit visible 4 cycles, dark 4 cycles, from the transfer on
    blink_en = 1'b1;
    send(4'd5, SEG5, 1'b0, "blink5");
    bus.bcd_valid = 1'b0;
    for (int j = 1; j < 16; j++) begin
      @(posedge CLOCK_50); #1;
      chk($sformatf("blink_phase%0d", j), 32'(HEX0),
          32'(((j % 8) < 4) ? SEG5 : OFF));
    end

    // Blanked zero stays dark regardless of blink phase
    blank_zero = 1'b1;
    send(4'd0, OFF, 1'b0, "bz0");
    bus.bcd_valid = 1'b0;
    for (int j = 1; j < 9; j++) begin
      @(posedge CLOCK_50); #1;
      chk($sformatf("bz0_cycle%0d", j), 32'(HEX0), 32'(OFF));
    end

    // Level inputs take effect only after the next edge
    blink_en = 1'b0; blank_zero = 1'b0;
    chk("level_change_before_edge", 32'(HEX0), 32'(OFF));
    @(posedge CLOCK_50); #1;
    chk("level_change_after_edge", 32'(HEX0), 32'(7'b0000001));

    // Reset during hold of an error code clears err asynchronously
    send(4'd12, DASH, 1'b1, "e12");
    bus.bcd_valid = 1'b0;
    @(posedge CLOCK_50); #3;
    RESET = 1'b1; #1;
    chk("rst_e12_hex", 32'(HEX0), 32'(OFF));
    chk("rst_e12_err", 32'(err), 32'd0);
    chk("rst_e12_ready", 32'(bus.bcd_ready), 32'd1);
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;

    // Reset during hold of 8, then 2 accepted on first edge after release
    send(4'd8, 7'b0000000, 1'b0, "d8");
    bus.bcd_valid = 1'b0;
    @(posedge CLOCK_50); #3;
    RESET = 1'b1; #1;
    chk("rst_d8_hex", 32'(HEX0), 32'(OFF));
    chk("rst_d8_ready", 32'(bus.bcd_ready), 32'd1);
    chk("rst_d8_err", 32'(err), 32'd0);
    begin
      exp_t x;
      x.hex = 7'b0010010; x.e = 1'b0; x.name = "d2_after_rst";
      exp_q.push_back(x);
    end
    bus.bcd_in = 4'd2; bus.bcd_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("rst_held_no_xfer", 32'(HEX0), 32'(OFF));
    RESET = 1'b0;
    @(posedge CLOCK_50); #1;
    bus.bcd_valid = 1'b0;
    hold_check("d2_after_rst");

    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
